// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and constants for the FIFO read-side stream engine.
// Imported by the buffer, interface users and the top.
package fifo_stream_pkg;
   localparam int PKT_CNT_W = 16;
   localparam int BUF_DEPTH = 2;
   typedef logic [1:0] buf_lvl_t;
endpackage

// File: rtl/fifo_rd_stream_if.sv
// Valid/ready output stream carrying packet-framed words.
// master drives data, slave drives ready.
interface fifo_rd_stream_if #(
   parameter int DW = 32
);
   logic          outValid;
   logic          outReady;
   logic [DW-1:0] outData;
   logic          outLast;

   modport master (
      output outValid,
      output outData,
      output outLast,
      input  outReady
   );

   modport slave (
      input  outValid,
      input  outData,
      input  outLast,
      output outReady
   );
endinterface

// File: rtl/fifo_rd_stream_buf2.sv
// Two-entry register buffer; push lands behind any held entry.
// Head is always entry0; a pop at level 2 shifts entry1 forward.
module stream_buf2
   import fifo_stream_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic          rdClk,
   input  logic          rdRst_n,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] pushData,
   output buf_lvl_t      level,
   output logic [DW-1:0] headData
);
   logic [DW-1:0] entry0;
   logic [DW-1:0] entry1;

   assign headData = entry0;

   // occupancy and entry storage, push behind head, pop shifts forward
   always_ff @(posedge rdClk) begin
      if (!rdRst_n) begin
         level  <= '0;
         entry0 <= '0;
         entry1 <= '0;
      end else begin
         level <= level + buf_lvl_t'(push) - buf_lvl_t'(pop);
         case (level)
            2'd0: begin
               if (push) entry0 <= pushData;
            end
            2'd1: begin
               if (push && pop) entry0 <= pushData;
               else if (push)   entry1 <= pushData;
            end
            2'd2: begin
               if (pop) entry0 <= entry1;
            end
            default: begin
               level <= '0;
            end
         endcase
      end
   end
endmodule

// File: rtl/fifo_rd_stream.sv
// Read-domain drain engine: pops the FIFO into a 2-entry buffer
// and emits a packet-framed valid/ready stream at 1 word/cycle.
module fifo_rd_stream
   import fifo_stream_pkg::*;
#(
   parameter int DW      = 32,
   parameter int PKT_LEN = 8
) (
   input  logic                 rdClk,
   input  logic                 rdRst_n,
   input  logic                 drainEn,
   input  logic                 fifoEmpty,
   input  logic [DW-1:0]        fifoRdData,
   output logic                 fifoRdEn,
   fifo_rd_stream_if.master     strm,
   output buf_lvl_t             bufLevel,
   output logic                 pktDone,
   output logic [PKT_CNT_W-1:0] pktCnt
);
   localparam int CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(PKT_LEN - 1);

   logic [CW-1:0] beat;
   logic          fire;
   logic          lastFire;

   assign fifoRdEn = rdRst_n & drainEn & ~fifoEmpty
                   & (bufLevel < buf_lvl_t'(BUF_DEPTH));

   assign strm.outValid = (bufLevel != '0);
   assign strm.outLast  = strm.outValid & (beat == LAST_BEAT);
   assign fire          = strm.outValid & strm.outReady;
   assign lastFire      = fire & strm.outLast;

   stream_buf2 #(.DW(DW)) u_buf (
      .rdClk    (rdClk),
      .rdRst_n  (rdRst_n),
      .push     (fifoRdEn),
      .pop      (fire),
      .pushData (fifoRdData),
      .level    (bufLevel),
      .headData (strm.outData)
   );

   // beat position within the packet, advanced only by accepted words
   always_ff @(posedge rdClk) begin
      if (!rdRst_n) begin
         beat <= '0;
      end else if (fire) begin
         beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
      end
   end

   // completed-packet pulse and wrapping packet count
   always_ff @(posedge rdClk) begin
      if (!rdRst_n) begin
         pktDone <= 1'b0;
         pktCnt  <= '0;
      end else begin
         pktDone <= lastFire;
         if (lastFire) pktCnt <= pktCnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: FIFO model plus scoreboard of words,
// framing and packet counters; second instance covers PKT_LEN=1.
module tb_fifo_rd_stream;
   import fifo_stream_pkg::*;

   localparam int DW = 32;

   logic rdClk = 1'b0;
   always #5 rdClk = ~rdClk;

   logic          rdRst_n;
   logic          drainEn;
   logic          fifoEmpty;
   logic [DW-1:0] fifoRdData;
   logic          fifoRdEn;
   buf_lvl_t      bufLevel;
   logic          pktDone;
   logic [15:0]   pktCnt;

   logic          drainEn1;
   logic          fifoEmpty1;
   logic [DW-1:0] fifoRdData1;
   logic          fifoRdEn1;
   buf_lvl_t      bufLevel1;
   logic          pktDone1;
   logic [15:0]   pktCnt1;

   fifo_rd_stream_if #(.DW(DW)) s0 ();
   fifo_rd_stream_if #(.DW(DW)) s1 ();

   fifo_rd_stream #(.DW(DW), .PKT_LEN(8)) u0 (
      .rdClk      (rdClk),
      .rdRst_n    (rdRst_n),
      .drainEn    (drainEn),
      .fifoEmpty  (fifoEmpty),
      .fifoRdData (fifoRdData),
      .fifoRdEn   (fifoRdEn),
      .strm       (s0),
      .bufLevel   (bufLevel),
      .pktDone    (pktDone),
      .pktCnt     (pktCnt)
   );

   fifo_rd_stream #(.DW(DW), .PKT_LEN(1)) u1 (
      .rdClk      (rdClk),
      .rdRst_n    (rdRst_n),
      .drainEn    (drainEn1),
      .fifoEmpty  (fifoEmpty1),
      .fifoRdData (fifoRdData1),
      .fifoRdEn   (fifoRdEn1),
      .strm       (s1),
      .bufLevel   (bufLevel1),
      .pktDone    (pktDone1),
      .pktCnt     (pktCnt1)
   );

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] fq[$];
   logic [DW-1:0] exp[$];
   int            expBeat = 0;
   logic [15:0]   expPktCnt = '0;
   logic          pendDone = 1'b0;
   bit            emptyForce = 1'b0;
   int            fires = 0;
   int            firstLast = -1;
   int            doneSeen = 0;

   task automatic updateFifo();
      fifoEmpty  = (fq.size() == 0) || emptyForce;
      fifoRdData = (fq.size() != 0) ? fq[0] : '0;
   endtask

   task automatic loadWords(input int n, input logic [DW-1:0] base);
      for (int i = 0; i < n; i++) begin
         fq.push_back(base + DW'(i));
         exp.push_back(base + DW'(i));
      end
   endtask

   task automatic tick();
      logic popNow, fireNow, rstNow, lastNow;
      logic [DW-1:0] want;
      updateFifo();
      @(negedge rdClk);
      rstNow  = !rdRst_n;
      popNow  = fifoRdEn;
      fireNow = s0.outValid & s0.outReady & !rstNow;
      checks++;
      if ((fifoRdEn & fifoEmpty) !== 1'b0) begin
         errors++;
         $display("FAIL popEmpty: rdEn=%b empty=%b", fifoRdEn, fifoEmpty);
      end
      checks++;
      if (pktDone !== pendDone) begin
         errors++;
         $display("FAIL pktDone: got %b want %b", pktDone, pendDone);
      end
      if (pktDone === 1'b1) doneSeen++;
      checks++;
      if (pktCnt !== expPktCnt) begin
         errors++;
         $display("FAIL pktCnt: got %0d want %0d", pktCnt, expPktCnt);
      end
      lastNow = 1'b0;
      if (fireNow) begin
         checks++;
         if (exp.size() == 0) begin
            errors++;
            $display("FAIL extraWord: got %h want none", s0.outData);
         end else begin
            want = exp.pop_front();
            if (s0.outData !== want) begin
               errors++;
               $display("FAIL outData: got %h want %h", s0.outData, want);
            end
         end
         lastNow = (expBeat == 7);
         checks++;
         if (s0.outLast !== lastNow) begin
            errors++;
            $display("FAIL outLast: got %b want %b beat %0d",
                     s0.outLast, lastNow, expBeat);
         end
         fires++;
         if (s0.outLast === 1'b1 && firstLast < 0) firstLast = fires;
      end
      @(posedge rdClk);
      #1;
      if (popNow && fq.size() != 0) void'(fq.pop_front());
      if (rstNow) begin
         exp       = fq;
         expBeat   = 0;
         expPktCnt = '0;
         pendDone  = 1'b0;
      end else begin
         pendDone = fireNow & lastNow;
         if (fireNow) begin
            expBeat = lastNow ? 0 : expBeat + 1;
            if (lastNow) expPktCnt = expPktCnt + 16'd1;
         end
      end
   endtask

   task automatic resetAll();
      rdRst_n = 1'b0;
      emptyForce = 1'b0;
      fq.delete();
      tick();
      tick();
      rdRst_n = 1'b1;
      fires = 0;
      firstLast = -1;
      doneSeen = 0;
   endtask

   task automatic drainAll(input int budget, input bit gapCheck);
      int n;
      n = 0;
      while (exp.size() > 0 && n < budget) begin
         tick();
         n++;
         if (gapCheck && fires > 0 && exp.size() > 0) begin
            checks++;
            if (s0.outValid !== 1'b1) begin
               errors++;
               $display("FAIL gap: outValid got %b want 1", s0.outValid);
            end
         end
      end
      checks++;
      if (exp.size() != 0) begin
         errors++;
         $display("FAIL drainTimeout: left %0d want 0", exp.size());
      end
      tick();
   endtask

   task automatic test_reset();
      rdRst_n = 1'b0;
      drainEn = 1'b1;
      s0.outReady = 1'b1;
      loadWords(4, 32'h100);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks += 4;
         if (fifoRdEn !== 1'b0) begin
            errors++;
            $display("FAIL rstRdEn: got %b want 0", fifoRdEn);
         end
         if (s0.outValid !== 1'b0) begin
            errors++;
            $display("FAIL rstValid: got %b want 0", s0.outValid);
         end
         if (bufLevel !== 2'd0) begin
            errors++;
            $display("FAIL rstLevel: got %0d want 0", bufLevel);
         end
         if (pktCnt !== 16'd0) begin
            errors++;
            $display("FAIL rstPktCnt: got %0d want 0", pktCnt);
         end
      end
      rdRst_n = 1'b1;
   endtask

   task automatic test_back_to_back();
      resetAll();
      loadWords(16, 32'h0);
      drainEn = 1'b1;
      s0.outReady = 1'b1;
      tick();
      checks++;
      if (s0.outValid !== 1'b1 || s0.outData !== 32'h0) begin
         errors++;
         $display("FAIL latency: valid %b data %h want 1 0",
                  s0.outValid, s0.outData);
      end
      drainAll(40, 1'b1);
      checks += 3;
      if (firstLast != 8) begin
         errors++;
         $display("FAIL firstLast: got %0d want 8", firstLast);
      end
      if (doneSeen != 2) begin
         errors++;
         $display("FAIL donePulses: got %0d want 2", doneSeen);
      end
      if (pktCnt !== 16'd2) begin
         errors++;
         $display("FAIL b2bPktCnt: got %0d want 2", pktCnt);
      end
   endtask

   task automatic test_backpressure();
      resetAll();
      loadWords(16, 32'h0);
      drainEn = 1'b1;
      s0.outReady = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         checks += 3;
         if (bufLevel !== 2'd2) begin
            errors++;
            $display("FAIL bpLevel: got %0d want 2", bufLevel);
         end
         if (fifoRdEn !== 1'b0) begin
            errors++;
            $display("FAIL bpRdEn: got %b want 0", fifoRdEn);
         end
         if (s0.outData !== 32'h0) begin
            errors++;
            $display("FAIL bpHold: got %h want 0", s0.outData);
         end
      end
      s0.outReady = 1'b1;
      drainAll(40, 1'b1);
   endtask

   task automatic test_drain_gap();
      int n;
      resetAll();
      loadWords(16, 32'h0);
      drainEn = 1'b1;
      s0.outReady = 1'b1;
      n = 0;
      while (fires < 3 && n < 20) begin
         tick();
         n++;
      end
      s0.outReady = 1'b0;
      tick();
      drainEn = 1'b0;
      s0.outReady = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (fifoRdEn !== 1'b0) begin
            errors++;
            $display("FAIL gapRdEn: got %b want 0", fifoRdEn);
         end
      end
      checks += 2;
      if (fires != 5) begin
         errors++;
         $display("FAIL gapDrained: got %0d words want 5", fires);
      end
      if (bufLevel !== 2'd0) begin
         errors++;
         $display("FAIL gapLevel: got %0d want 0", bufLevel);
      end
      drainEn = 1'b1;
      drainAll(40, 1'b0);
      checks++;
      if (firstLast != 8) begin
         errors++;
         $display("FAIL gapLast: got %0d want 8", firstLast);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      resetAll();
      loadWords(16, 32'h200);
      drainEn = 1'b1;
      s0.outReady = 1'b1;
      n = 0;
      while (fires < 3 && n < 20) begin
         tick();
         n++;
      end
      s0.outReady = 1'b0;
      tick();
      tick();
      checks++;
      if (bufLevel !== 2'd2) begin
         errors++;
         $display("FAIL midLevel: got %0d want 2", bufLevel);
      end
      rdRst_n = 1'b0;
      tick();
      tick();
      rdRst_n = 1'b1;
      checks++;
      if (bufLevel !== 2'd0 || s0.outValid !== 1'b0) begin
         errors++;
         $display("FAIL midClear: level %0d valid %b want 0 0",
                  bufLevel, s0.outValid);
      end
      fires = 0;
      firstLast = -1;
      s0.outReady = 1'b1;
      drainAll(40, 1'b0);
      checks++;
      if (firstLast != 8) begin
         errors++;
         $display("FAIL midLast: got %0d want 8", firstLast);
      end
   endtask

   task automatic test_random();
      int pushed, n;
      resetAll();
      pushed = 0;
      n = 0;
      while (fires < 10000 && n < 40000) begin
         if (pushed < 10000 && fq.size() < 8 && $urandom_range(0, 3) != 0) begin
            fq.push_back($urandom);
            exp.push_back(fq[fq.size() - 1]);
            pushed++;
         end
         emptyForce  = ($urandom_range(0, 4) == 0);
         s0.outReady = ($urandom_range(0, 9) < 7);
         drainEn     = ($urandom_range(0, 19) != 0);
         tick();
         n++;
      end
      emptyForce = 1'b0;
      checks++;
      if (fires != 10000) begin
         errors++;
         $display("FAIL randomWords: got %0d want 10000", fires);
      end
   endtask

   task automatic test_pktlen1();
      logic [DW-1:0] q1[$];
      logic [DW-1:0] e1[$];
      logic [DW-1:0] want;
      logic pop1, fire1;
      int got, n;
      for (int i = 0; i < 4; i++) begin
         q1.push_back(32'hA0 + DW'(i));
         e1.push_back(32'hA0 + DW'(i));
      end
      drainEn1 = 1'b1;
      s1.outReady = 1'b1;
      got = 0;
      n = 0;
      while (got < 4 && n < 20) begin
         fifoEmpty1  = (q1.size() == 0);
         fifoRdData1 = (q1.size() != 0) ? q1[0] : '0;
         @(negedge rdClk);
         pop1  = fifoRdEn1;
         fire1 = s1.outValid & s1.outReady;
         if (fire1) begin
            want = e1.pop_front();
            checks += 2;
            if (s1.outData !== want) begin
               errors++;
               $display("FAIL len1Data: got %h want %h", s1.outData, want);
            end
            if (s1.outLast !== 1'b1) begin
               errors++;
               $display("FAIL len1Last: got %b want 1", s1.outLast);
            end
            got++;
         end
         @(posedge rdClk);
         #1;
         if (pop1 && q1.size() != 0) void'(q1.pop_front());
         n++;
      end
      fifoEmpty1 = 1'b1;
      @(posedge rdClk);
      #1;
      checks += 2;
      if (got != 4) begin
         errors++;
         $display("FAIL len1Words: got %0d want 4", got);
      end
      if (pktCnt1 !== 16'd4) begin
         errors++;
         $display("FAIL len1PktCnt: got %0d want 4", pktCnt1);
      end
   endtask

   initial begin
      rdRst_n     = 1'b0;
      drainEn     = 1'b0;
      fifoEmpty   = 1'b1;
      fifoRdData  = '0;
      s0.outReady = 1'b0;
      drainEn1    = 1'b0;
      fifoEmpty1  = 1'b1;
      fifoRdData1 = '0;
      s1.outReady = 1'b1;
      test_reset();
      test_back_to_back();
      test_backpressure();
      test_drain_gap();
      test_reset_mid();
      test_pktlen1();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
